// File: rtl/gamma_lut_controller.sv
// Programming sequencer for a double-buffered per-channel gamma LUT: byte commands in, LUT write strobes out.
// Writes appear one cycle after acceptance; broadcast and pending-swap states hold cmd_ready low.
module gamma_lut_controller #(
    parameter int segments   = 1,
    parameter int cyclewidth = 8,
    parameter int bitwidth   = 8,
    parameter int datawidth  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [1:0]                    cmd_op,
    input  logic [datawidth-1:0]          cmd_data,
    input  logic                          frame_start,
    output logic                          lut_we,
    output logic                          lut_bank,
    output logic [$clog2(3*segments)-1:0] lut_chan,
    output logic [bitwidth-1:0]           lut_addr,
    output logic [cyclewidth-1:0]         lut_wdata,
    output logic                          active_bank,
    output logic                          swap_pending
);

    localparam int C  = 3 * segments;
    localparam int CW = $clog2(C);
    localparam logic [CW-1:0]        LAST_CHAN = CW'(C - 1);
    localparam logic [datawidth-1:0] SEL_BCAST = datawidth'(C);

    localparam logic [1:0] OP_SELECT = 2'd0;
    localparam logic [1:0] OP_ADDR   = 2'd1;
    localparam logic [1:0] OP_WRITE  = 2'd2;

    typedef enum logic [1:0] {IDLE, BCAST, WAIT_SWAP} state_t;

    state_t                 state_q, state_d;
    logic                   active_q, active_d;
    logic [datawidth-1:0]   sel_q, sel_d;
    logic [bitwidth-1:0]    ptr_q, ptr_d;
    logic                   we_q, we_d;
    logic [CW-1:0]          chan_q, chan_d;
    logic [bitwidth-1:0]    addr_q, addr_d;
    logic [cyclewidth-1:0]  wdata_q, wdata_d;
    logic                   xfer;

    assign cmd_ready    = (state_q == IDLE) && !rst;
    assign xfer         = cmd_valid && cmd_ready;
    assign swap_pending = (state_q == WAIT_SWAP);
    assign active_bank  = active_q;
    assign lut_bank     = ~active_q;
    assign lut_we       = we_q;
    assign lut_chan     = chan_q;
    assign lut_addr     = addr_q;
    assign lut_wdata    = wdata_q;

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        sel_d    = sel_q;
        ptr_d    = ptr_q;
        we_d     = 1'b0;
        chan_d   = chan_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    case (cmd_op)
                        OP_SELECT: sel_d = cmd_data;
                        OP_ADDR:   ptr_d = cmd_data[bitwidth-1:0];
                        OP_WRITE: begin
                            we_d    = 1'b1;
                            addr_d  = ptr_q;
                            wdata_d = cmd_data[cyclewidth-1:0];
                            if (sel_q >= SEL_BCAST) begin
                                chan_d  = '0;
                                state_d = BCAST;
                            end else begin
                                chan_d = sel_q[CW-1:0];
                                ptr_d  = ptr_q + 1'b1;
                            end
                        end
                        default: state_d = WAIT_SWAP;
                    endcase
                end
            end
            BCAST: begin
                // addr/wdata were captured on entry; only the channel walks
                if (chan_q == LAST_CHAN) begin
                    state_d = IDLE;
                    ptr_d   = ptr_q + 1'b1;
                end else begin
                    we_d   = 1'b1;
                    chan_d = chan_q + 1'b1;
                end
            end
            WAIT_SWAP: begin
                if (frame_start) begin
                    active_d = ~active_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            active_q <= 1'b0;
            sel_q    <= '0;
            ptr_q    <= '0;
            we_q     <= 1'b0;
            chan_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            sel_q    <= sel_d;
            ptr_q    <= ptr_d;
            we_q     <= we_d;
            chan_q   <= chan_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

endmodule

// File: doc/gamma_lut_controller.md
Name: gamma_lut_controller

Overview:
Runtime programming sequencer for a double-buffered, per-channel gamma LUT feeding the display color encoder. It accepts a byte-wide command stream (valid/ready) to select a channel, set an address, and write entries, including an all-channel broadcast. It drives the LUT memory write port for the inactive bank and swaps the active bank atomically at a frame boundary on commit.

Parameters:
segments, 1, number of RGB segments; channel count C = 3*segments
cyclewidth, 8, LUT entry width (PWM cycle count)
bitwidth, 8, LUT address width; depth 2**bitwidth
datawidth, 8, command payload width; must be >= cyclewidth, bitwidth, clog2(C+1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller accepts command this cycle
cmd_op  in  2  0=SELECT, 1=ADDR, 2=WRITE, 3=COMMIT
cmd_data  in  datawidth  payload
frame_start  in  1  one-cycle pulse at start of display frame
lut_we  out  1  LUT write strobe
lut_bank  out  1  bank being written (always ~active_bank)
lut_chan  out  clog2(C)  channel index of write
lut_addr  out  bitwidth  entry address of write
lut_wdata  out  cyclewidth  entry value
active_bank  out  1  bank read by encoder
swap_pending  out  1  high while COMMIT waits for frame_start

Behaviour:
- One clock domain; one clock, synchronous active-high reset named rst, clock named clk.
- Reset: state IDLE, active_bank=0, lut_bank=1, lut_we=0, lut_chan=0, lut_addr=0, lut_wdata=0, swap_pending=0, selected channel=0, address pointer=0. Reset mid-broadcast or mid-wait aborts; no further lut_we; pending swap discarded.
- Handshake: transfer when cmd_valid & cmd_ready. cmd_ready=1 only in IDLE and not rst. cmd_op/cmd_data ignored without transfer.
- States: IDLE, BCAST, WAIT_SWAP.
- SELECT: sel <= cmd_data; value >= C means broadcast mode. Stay IDLE.
- ADDR: pointer <= cmd_data[bitwidth-1:0]. Stay IDLE.
- WRITE, non-broadcast, accepted cycle N: cycle N+1 lut_we=1, lut_chan=sel, lut_addr=pointer, lut_wdata=cmd_data[cyclewidth-1:0]; pointer increments in the same update (visible for next write). Back-to-back WRITEs give lut_we every cycle.
- WRITE, broadcast, accepted cycle N: enter BCAST; cycles N+1..N+C lut_we=1, lut_chan=0..C-1 ascending, same addr/data; cmd_ready=0 cycles N+1..N+C; pointer increments once, after the last channel; return IDLE, cmd_ready=1 at N+C+1.
- Pointer wraps 2**bitwidth-1 -> 0.
- lut_we=0 on every cycle not listed above; lut_chan/addr/wdata hold last values.
- COMMIT accepted cycle N: enter WAIT_SWAP, swap_pending=1 from N+1. A frame_start in cycle N itself is ignored. First frame_start seen in WAIT_SWAP at cycle M: at M+1 active_bank toggles, lut_bank=~new active_bank, swap_pending=0, state IDLE, cmd_ready=1. Pointer and sel unchanged by swap.
- frame_start outside WAIT_SWAP has no effect.
- No writes ever target active_bank.
- Newly exposed write bank after swap holds stale contents; software rewrites as needed.

Test Plan:
- Reset then idle: active_bank=0, lut_bank=1, lut_we=0, cmd_ready=1, swap_pending=0.
- SELECT 1, ADDR 0xFE, WRITE 0x10, WRITE 0x20, WRITE 0x30 back-to-back -> three consecutive lut_we pulses, chan 1, addr 0xFE,0xFF,0x00, wdata 0x10,0x20,0x30, bank 1.
- segments=2: SELECT 7, ADDR 5, WRITE 0xAA -> six lut_we cycles, chan 0..5, addr 5, data 0xAA; cmd_ready low those six cycles; next WRITE lands at addr 6.
- COMMIT with frame_start coincident on accept cycle, then frame_start 10 cycles later -> swap_pending high ~11 cycles, active_bank 0->1 and lut_bank 1->0 exactly one cycle after second pulse; cmd_ready low throughout wait.
- cmd_valid held with COMMIT pending, WRITE presented -> not accepted, no lut_we until swap completes, then accepted next cycle.
- rst asserted on 3rd cycle of broadcast (segments=2) -> lut_we=0 the following cycle, all outputs at reset values, no swap.
